hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipeline.
- Forwards operands from EX/MEM or MEM/WB into NUM_SRC ALU source muxes.
- Detects load-use hazards and holds PC/IF-ID while inserting LOAD_LAT bubbles into ID/EX.
- Keeps a saturating stall-cycle counter. Sits between the ID/EX register and the ALU input muxes, next to the hazard control on PC/IF-ID.

Parameters:
- NUM_SRC, 2: number of operand channels (rs, rt, ...).
- REG_AW, 5: register index width.
- LOAD_LAT, 1: bubbles required after a load before a dependent op can issue; range 1..7.
- CNT_W, 32: stall counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- ifid_src_valid  in  NUM_SRC  source n of the IF/ID instruction is read.
- ifid_src_reg  in  NUM_SRC*REG_AW  IF/ID source indices; channel n is at [n*REG_AW +: REG_AW].
- idex_src_valid  in  NUM_SRC  source n of the ID/EX instruction is read. I-type drives the rt channel to 0.
- idex_src_reg  in  NUM_SRC*REG_AW  ID/EX source indices.
- idex_reg_write  in  1  ID/EX writes a register.
- idex_mem_read  in  1  ID/EX is a load.
- idex_dst  in  REG_AW  ID/EX destination.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_mem_read  in  1  EX/MEM is a load; its data is not yet available.
- exmem_dst  in  REG_AW  EX/MEM destination.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_dst  in  REG_AW  MEM/WB destination.
- fwd_sel  out  NUM_SRC*2  per channel: 0 = register file, 1 = EX/MEM, 2 = MEM/WB; 3 is never driven.
- pc_write  out  1  0 freezes the PC.
- ifid_write  out  1  0 holds IF/ID.
- idex_flush  out  1  1 loads a bubble into ID/EX.
- stall_count  out  CNT_W  total stall cycles since reset.

Behaviour:
- Reset (async) sets: state=IDLE, remaining=0, held_dst=0, stall_count=0.
- Outputs during reset: pc_write=1, ifid_write=1, idex_flush=0, fwd_sel=0.
- fwd_sel is combinational and evaluated per channel n:
  - 1 if idex_src_valid[n], exmem_reg_write, !exmem_mem_read, exmem_dst!=0 and exmem_dst==src.
  - Otherwise 2 if idex_src_valid[n], memwb_reg_write, memwb_dst!=0 and memwb_dst==src.
  - Otherwise 0.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded. An invalid channel always gives 0.
- hit is combinational:
  - True when state==IDLE, idex_mem_read, idex_reg_write, idex_dst!=0, and some n has ifid_src_valid[n] with ifid_src_reg[n]==idex_dst.
- stall_now = hit OR state==STALL.
  - When stall_now: pc_write=0, ifid_write=0, idex_flush=1.
  - Otherwise: pc_write=1, ifid_write=1, idex_flush=0.
  - The first bubble is asserted in the same cycle as detection (zero latency).
- FSM transitions:
  - IDLE, hit, LOAD_LAT==1: stay in IDLE. This is the single-bubble case.
  - IDLE, hit, LOAD_LAT>1: go to STALL with remaining=LOAD_LAT-1 and held_dst=idex_dst.
  - STALL: decrement remaining each cycle; move to IDLE on the edge where remaining==1. This gives exactly LOAD_LAT total stall cycles.
  - In STALL, a new hit is not evaluated, because IF/ID is frozen and ID/EX holds bubbles.
- stall_count increments by 1 on every clock edge where stall_now==1. It saturates at all-ones and does not wrap.
- Reset asserted during STALL: immediate return to IDLE, stall outputs deassert asynchronously, and the counter clears.
- A load whose dst is 0 never stalls.
- A load whose dst matches both sources causes one stall sequence, not two.
- A load in EX/MEM with LOAD_LAT>1 is never forwarded from EX/MEM; its value comes from MEM/WB on a later cycle.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2.
  - State encoding IDLE/STALL.
  - Defaults for REG_AW and NUM_SRC.
- Sub-module fwd_select: one per channel via generate. It is the pure combinational priority compare for one source and returns 2 bits.
- The FSM, counter and hazard-control outputs stay in the top module.

Test Plan:
1. Reset held for 3 cycles, then released -> fwd_sel=0, pc_write=1, idex_flush=0, stall_count=0.
2. EX/MEM writes r8 and MEM/WB writes r8; ID/EX src0=r8 valid, src1=r8 invalid -> fwd_sel ch0=1, ch1=0. Then drop exmem_reg_write -> ch0=2.
3. Both stages write r0; src0=r0 -> fwd_sel ch0=0 in both cases.
4. LOAD_LAT=1: ID/EX lw to r9, IF/ID src1=r9 -> exactly 1 cycle with pc_write=0 and idex_flush=1, and stall_count=1.
5. LOAD_LAT=3: same stimulus -> 3 consecutive stall cycles, then normal operation, and stall_count=3. During the sequence, exmem_mem_read=1 with exmem_dst=r9 gives fwd_sel=0 (no EX/MEM forward).
6. LOAD_LAT=3: assert Reset during the 2nd stall cycle -> pc_write=1 immediately, state=IDLE, stall_count=0. After release, no residual stall occurs.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit: mux selects, FSM states, defaults.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam int DEF_REG_AW  = 5;
  localparam int DEF_NUM_SRC = 2;

endpackage

// File: rtl/fwd_select.sv
// Priority compare for one ALU source: EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              src_valid,
  input  logic [REG_AW-1:0] src_reg,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_read,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_dst,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    // A load in EX/MEM has no data yet, so it must not win the EX/MEM path.
    if (src_valid && exmem_reg_write && !exmem_mem_read &&
        (exmem_dst != '0) && (exmem_dst == src_reg)) begin
      sel = FWD_EXMEM;
    end else if (src_valid && memwb_reg_write &&
                 (memwb_dst != '0) && (memwb_dst == src_reg)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding plus load-use stall control with a saturating stall counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_SRC-1:0]        ifid_src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_src_reg,
  input  logic [NUM_SRC-1:0]        idex_src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] idex_src_reg,
  input  logic                      idex_reg_write,
  input  logic                      idex_mem_read,
  input  logic [REG_AW-1:0]         idex_dst,
  input  logic                      exmem_reg_write,
  input  logic                      exmem_mem_read,
  input  logic [REG_AW-1:0]         exmem_dst,
  input  logic                      memwb_reg_write,
  input  logic [REG_AW-1:0]         memwb_dst,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      idex_flush,
  output logic [CNT_W-1:0]          stall_count
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [NUM_SRC-1:0] src_hit;
  logic             hit;
  logic             stall_now;

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_fwd
    logic [1:0] sel_raw;
    fwd_select #(.REG_AW(REG_AW)) u_fwd_select (
      .src_valid       (idex_src_valid[n]),
      .src_reg         (idex_src_reg[n*REG_AW +: REG_AW]),
      .exmem_reg_write (exmem_reg_write),
      .exmem_mem_read  (exmem_mem_read),
      .exmem_dst       (exmem_dst),
      .memwb_reg_write (memwb_reg_write),
      .memwb_dst       (memwb_dst),
      .sel             (sel_raw)
    );
    assign fwd_sel[n*2 +: 2] = Reset ? FWD_RF : sel_raw;
  end

  always_comb begin
    for (int n = 0; n < NUM_SRC; n++) begin
      src_hit[n] = ifid_src_valid[n] && (ifid_src_reg[n*REG_AW +: REG_AW] == idex_dst);
    end
  end

  assign hit = (state_q == IDLE) && idex_mem_read && idex_reg_write &&
               (idex_dst != '0) && (|src_hit);

  // Combinational so the first bubble lands in the detection cycle.
  assign stall_now  = !Reset && (hit || (state_q == STALL));
  assign pc_write   = !stall_now;
  assign ifid_write = !stall_now;
  assign idex_flush = stall_now;
  assign stall_count = stall_count_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (hit && (LOAD_LAT > 1)) begin
          state_d     = STALL;
          remaining_d = LAT_M1;
        end
      end
      STALL: begin
        if (remaining_q == 3'd1) begin
          state_d     = IDLE;
          remaining_d = 3'd0;
        end else begin
          remaining_d = remaining_q - 3'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_now && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      remaining_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
